uart_rx_ctrl: RTL and testbench

//  Receive-side frame sequencer for the UART RX path.
//  - Oversamples RX_IN, validates the start bit and deserialises 8 data bits LSB-first.
//  - Captures the optional parity bit, drives the parity checker (par_chk_en / data_parity_chk), checks the stop bit.
//  - Reports each frame as data or error; sits between the RX input synchroniser and the register/FIFO consumer.

---
 rtl/uart_rx_ctrl.sv | 118 +++++++++++
 tb/tb_uart_rx_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: oversampled start validation, LSB-first deserialisation,
// optional parity capture and stop-bit check, with one result pulse per completed frame.
module uart_rx_ctrl #(
  parameter int PRESCALE = 8,
  parameter int DW       = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          RX_IN,
  input  logic          PAR_EN,
  input  logic          par_err,
  output logic          par_chk_en,
  output logic [DW:0]   data_parity_chk,
  output logic [DW-1:0] P_DATA,
  output logic          data_valid,
  output logic          par_err_o,
  output logic          stp_err,
  output logic          busy,
  output logic [2:0]    state_dbg
);

  localparam int EW = $clog2(PRESCALE);
  localparam int BW = $clog2(DW);

  localparam logic [EW-1:0] EDGE_MID  = EW'(PRESCALE / 2);
  localparam logic [EW-1:0] EDGE_LAST = EW'(PRESCALE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DW - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]    state;
  logic [EW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DW-1:0] shreg;
  logic          par_bit;
  logic          par_en_q;
  logic          mid;
  logic          bit_end;

  assign mid     = (edge_cnt == EDGE_MID);
  assign bit_end = (edge_cnt == EDGE_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      par_en_q   <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err_o  <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err_o  <= 1'b0;
      stp_err    <= 1'b0;

      if (state == IDLE || bit_end) edge_cnt <= '0;
      else                          edge_cnt <= edge_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (!RX_IN) begin
            state    <= START;
            par_en_q <= PAR_EN;
            par_bit  <= 1'b0;
          end
        end
        START: begin
          if (mid && RX_IN) begin
            state    <= IDLE;
            edge_cnt <= '0;
          end else if (bit_end) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (mid) shreg[bit_cnt] <= RX_IN;
          if (bit_end) begin
            if (bit_cnt == BIT_LAST) state <= par_en_q ? PARITY : STOP;
            else                     bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (mid)     par_bit <= RX_IN;
          if (bit_end) state   <= STOP;
        end
        STOP: begin
          // Leave at the stop mid-sample so a back-to-back start edge is not missed.
          if (mid) begin
            state    <= IDLE;
            edge_cnt <= '0;
            if (!RX_IN)                   stp_err   <= 1'b1;
            else if (par_en_q && par_err) par_err_o <= 1'b1;
            else begin
              data_valid <= 1'b1;
              P_DATA     <= shreg;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign data_parity_chk = {par_bit, shreg};
  assign par_chk_en      = (state == STOP) && par_en_q;
  assign busy            = (state != IDLE);
  assign state_dbg       = state;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frame timing, parity/stop errors, glitch, reset,
// back-to-back and break scenarios, with an expected-byte queue for P_DATA.
module tb_uart_rx_ctrl;

  localparam int P = 8;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       par_en;
  logic       par_err;
  logic       par_chk_en;
  logic [8:0] data_parity_chk;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err_o;
  logic       stp_err;
  logic       busy;
  logic [2:0] state_dbg;

  uart_rx_ctrl #(.PRESCALE(P), .DW(8)) dut (
    .CLK             (clk),
    .RST             (rst),
    .RX_IN           (rx),
    .PAR_EN          (par_en),
    .par_err         (par_err),
    .par_chk_en      (par_chk_en),
    .data_parity_chk (data_parity_chk),
    .P_DATA          (p_data),
    .data_valid      (data_valid),
    .par_err_o       (par_err_o),
    .stp_err         (stp_err),
    .busy            (busy),
    .state_dbg       (state_dbg)
  );

  // Even-parity checker (PAR_TYP = 0) fed from the block's outputs.
  assign par_err = par_chk_en & (^data_parity_chk);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int t0       = 0;
  int n_dv, n_pe, n_se;
  int dv_cyc, pe_cyc, se_cyc, fall_cyc;
  logic busy_prev = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clr();
    n_dv = 0; n_pe = 0; n_se = 0;
    dv_cyc = -1; pe_cyc = -1; se_cyc = -1; fall_cyc = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (data_valid) begin
      n_dv++;
      dv_cyc = cyc;
      if (exp_q.size() > 0) check("p_data_sb", 32'(p_data), 32'(exp_q.pop_front()));
      else                  check("dv_unexpected", 32'(exp_q.size()), 32'd1);
    end
    if (par_err_o) begin n_pe++; pe_cyc = cyc; end
    if (stp_err)   begin n_se++; se_cyc = cyc; end
    if (busy_prev && !busy) fall_cyc = cyc;
    busy_prev = busy;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pbit,
                            input logic sbit, input int tail, input int rst_at);
    logic [10:0] fr;
    int nb;
    fr = '1;
    fr[0]   = 1'b0;
    fr[8:1] = d;
    if (pe) begin fr[9] = pbit; fr[10] = sbit; nb = 11; end
    else    begin fr[9] = sbit; nb = 10; end
    par_en = pe;
    t0 = cyc;
    for (int c = 0; c < nb * P + tail; c++) begin
      rx = (c < nb * P) ? fr[c / P] : 1'b1;
      if (c == rst_at) rst = 1'b1;
      tick();
      rst = 1'b0;
      if (c == rst_at) begin
        check("rst_mid_busy",  32'(busy), 32'd0);
        check("rst_mid_state", 32'(state_dbg), 32'd0);
        check("rst_mid_pdata", 32'(p_data), 32'd0);
        check("rst_mid_dpc",   32'(data_parity_chk), 32'd0);
        check("rst_mid_pulse", 32'({data_valid, par_err_o, stp_err}), 32'd0);
      end
    end
  endtask

  int first_dv;

  initial begin
    rst = 1'b1; rx = 1'b1; par_en = 1'b0;
    clr();
    repeat (3) tick();
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_pdata", 32'(p_data), 32'd0);
    check("rst_dpc",   32'(data_parity_chk), 32'd0);
    check("rst_pulse", 32'({data_valid, par_err_o, stp_err, par_chk_en}), 32'd0);
    rst = 1'b0;
    repeat (4) tick();

    // No parity, good frame
    clr(); exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 12, -1);
    check("np_dv_cnt", 32'(n_dv), 32'd1);
    check("np_dv_lat", 32'(dv_cyc - t0), 32'd78);
    check("np_err",    32'(n_pe + n_se), 32'd0);
    check("np_pdata",  32'(p_data), 32'hA5);
    check("np_busy",   32'(busy), 32'd0);

    // Parity, correct parity bit
    clr(); exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 12, -1);
    check("par_ok_dv",    32'(n_dv), 32'd1);
    check("par_ok_lat",   32'(dv_cyc - t0), 32'd86);
    check("par_ok_err",   32'(n_pe + n_se), 32'd0);
    check("par_ok_pdata", 32'(p_data), 32'h3C);
    check("par_ok_dpc",   32'(data_parity_chk), 32'h03C);

    // Parity, wrong parity bit
    clr();
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 12, -1);
    check("par_bad_pe",    32'(n_pe), 32'd1);
    check("par_bad_lat",   32'(pe_cyc - t0), 32'd86);
    check("par_bad_dv",    32'(n_dv + n_se), 32'd0);
    check("par_bad_pdata", 32'(p_data), 32'h3C);
    check("par_bad_dpc",   32'(data_parity_chk), 32'h13C);

    // Start glitch of two cycles
    clr(); t0 = cyc;
    rx = 1'b0;
    tick();
    check("gl_busy_rise", 32'(busy), 32'd1);
    tick();
    rx = 1'b1;
    repeat (20) tick();
    check("gl_fall",  32'(fall_cyc - t0), 32'd6);
    check("gl_pulse", 32'(n_dv + n_pe + n_se), 32'd0);
    check("gl_busy",  32'(busy), 32'd0);

    // Stop bit low, no parity
    clr();
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 12, -1);
    check("stp_se",    32'(n_se), 32'd1);
    check("stp_lat",   32'(se_cyc - t0), 32'd78);
    check("stp_other", 32'(n_dv + n_pe), 32'd0);
    check("stp_pdata", 32'(p_data), 32'h3C);

    // Stop bit low plus bad parity: stop error wins
    clr();
    send_frame(8'h55, 1'b1, 1'b1, 1'b0, 12, -1);
    check("stp_par_se",    32'(n_se), 32'd1);
    check("stp_par_lat",   32'(se_cyc - t0), 32'd86);
    check("stp_par_other", 32'(n_dv + n_pe), 32'd0);

    // Reset during data bit 3, then a good frame
    clr();
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 12, 35);
    check("rst_fr_pulse", 32'(n_dv + n_pe + n_se), 32'd0);
    clr(); exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 12, -1);
    check("post_rst_dv",    32'(n_dv), 32'd1);
    check("post_rst_lat",   32'(dv_cyc - t0), 32'd78);
    check("post_rst_pdata", 32'(p_data), 32'hFF);

    // Back-to-back frames
    clr(); exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, 0, -1);
    first_dv = dv_cyc;
    send_frame(8'h34, 1'b0, 1'b0, 1'b1, 12, -1);
    check("b2b_dv",    32'(n_dv), 32'd2);
    check("b2b_gap",   32'(dv_cyc - first_dv), 32'(P * 10));
    check("b2b_pdata", 32'(p_data), 32'h34);

    // Line break: two frame times low, then recovery
    clr(); par_en = 1'b0;
    rx = 1'b0;
    repeat (160) tick();
    rx = 1'b1;
    repeat (12) tick();
    check("brk_se",   32'(n_se), 32'd2);
    check("brk_dv",   32'(n_dv + n_pe), 32'd0);
    check("brk_busy", 32'(busy), 32'd0);
    clr(); exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 12, -1);
    check("brk_rec_dv",    32'(n_dv), 32'd1);
    check("brk_rec_pdata", 32'(p_data), 32'h5A);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
